reaction_timer: RTL

Parametrised reaction-game core for the FPGA reaction game, sitting between the debounced button inputs and the 7-segment display driver. The player selects one of `NUM_MODES` difficulty levels, arms the timer, and waits out a pseudo-random hold-off. The score counter then advances at the mode's tick rate until the stop press. Adds false-start detection, score saturation and an optional best-score register.

---
 rtl/reaction_timer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/reaction_timer.sv
// Reaction-game core: mode select, random hold-off, scored run with false-start detection.
// Optional best-score register enabled by defining REACTION_BEST_EN.
module reaction_timer #(
    parameter int NUM_MODES  = 3,
    parameter int BASE_TICKS = 100000,
    parameter int RESET_MODE = 1,
    parameter int NUM_W      = 14,
    parameter int MIN_DELAY  = 500000,
    parameter int DELAY_W    = 20
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         btnU,
    input  logic                         btnD,
    input  logic                         btnS,
    output logic [1:0]                   phase,
    output logic [$clog2(NUM_MODES)-1:0] mode,
    output logic [NUM_W-1:0]             number,
    output logic                         false_start,
    output logic [NUM_W-1:0]             best,
    output logic                         new_best
);

    localparam int MODE_W = $clog2(NUM_MODES);
    localparam int TICK_W = $clog2(BASE_TICKS) + NUM_MODES;
    localparam int DLY_W  = $clog2(MIN_DELAY + (1 << DELAY_W)) + 1;
    localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        S_SELECT = 2'd0,
        S_ARMED  = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } phase_e;

    phase_e             phase_q, phase_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic [NUM_W-1:0]   number_q, number_d;
    logic               fs_q, fs_d;
    logic [DLY_W-1:0]   delay_q, delay_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [23:0]        lfsr_q, lfsr_d;
    logic               prev_u_q, prev_u_d;
    logic               prev_d_q, prev_d_d;
    logic               prev_s_q, prev_s_d;
    logic               rise_u, rise_d, rise_s;
    logic [TICK_W-1:0]  period;

    assign rise_u = btnU & ~prev_u_q;
    assign rise_d = btnD & ~prev_d_q;
    assign rise_s = btnS & ~prev_s_q;

    // Slowest mode (0) gets the longest period.
    assign period = TICK_W'(BASE_TICKS) << (MODE_MAX - mode_q);

    always_comb begin
        phase_d  = phase_q;
        mode_d   = mode_q;
        number_d = number_q;
        fs_d     = fs_q;
        delay_d  = delay_q;
        tick_d   = tick_q;
        prev_u_d = btnU;
        prev_d_d = btnD;
        prev_s_d = btnS;
        lfsr_d   = {lfsr_q[22:0], lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16]};
        case (phase_q)
            S_SELECT: begin
                if (rise_u && !rise_d && mode_q != MODE_MAX) begin
                    mode_d = mode_q + MODE_W'(1);
                end else if (rise_d && !rise_u && mode_q != '0) begin
                    mode_d = mode_q - MODE_W'(1);
                end
                if (rise_s) begin
                    phase_d  = S_ARMED;
                    delay_d  = DLY_W'(MIN_DELAY) + DLY_W'(lfsr_q[DELAY_W-1:0]);
                    number_d = '0;
                    fs_d     = 1'b0;
                end
            end
            S_ARMED: begin
                // A press on the final hold-off cycle is still a false start.
                if (rise_s) begin
                    phase_d  = S_DONE;
                    fs_d     = 1'b1;
                    number_d = '0;
                end else if (delay_q == '0) begin
                    phase_d = S_RUN;
                    tick_d  = '0;
                end else begin
                    delay_d = delay_q - DLY_W'(1);
                end
            end
            S_RUN: begin
                if (tick_q == period - TICK_W'(1)) begin
                    tick_d = '0;
                    if (number_q != '1) begin
                        number_d = number_q + NUM_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
                if (rise_s) begin
                    phase_d = S_DONE;
                end
            end
            S_DONE: begin
                if (rise_s) begin
                    phase_d = S_SELECT;
                end
            end
            default: phase_d = S_SELECT;
        endcase
    end

    // Button history resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= S_SELECT;
            mode_q   <= MODE_W'(RESET_MODE);
            number_q <= '0;
            fs_q     <= 1'b0;
            delay_q  <= '0;
            tick_q   <= '0;
            lfsr_q   <= 24'h000001;
            prev_u_q <= 1'b1;
            prev_d_q <= 1'b1;
            prev_s_q <= 1'b1;
        end else begin
            phase_q  <= phase_d;
            mode_q   <= mode_d;
            number_q <= number_d;
            fs_q     <= fs_d;
            delay_q  <= delay_d;
            tick_q   <= tick_d;
            lfsr_q   <= lfsr_d;
            prev_u_q <= prev_u_d;
            prev_d_q <= prev_d_d;
            prev_s_q <= prev_s_d;
        end
    end

    assign phase       = phase_q;
    assign mode        = mode_q;
    assign number      = number_q;
    assign false_start = fs_q;

`ifdef REACTION_BEST_EN
    logic [NUM_W-1:0] best_q, best_d;
    logic             new_best_q, new_best_d;

    // Only a stop from RUN is a valid score; the final score includes a same-cycle increment.
    always_comb begin
        best_d     = best_q;
        new_best_d = 1'b0;
        if (phase_q == S_RUN && rise_s && number_d < best_q) begin
            best_d     = number_d;
            new_best_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q     <= '1;
            new_best_q <= 1'b0;
        end else begin
            best_q     <= best_d;
            new_best_q <= new_best_d;
        end
    end

    assign best     = best_q;
    assign new_best = new_best_q;
`else
    assign best     = '1;
    assign new_best = 1'b0;
`endif

endmodule
